// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: brings a 16-bit SPI frame into the clk domain, validates its length
// and command, and applies it to a small LED configuration register file.
module spi_frame_ctrl #(
   parameter int DATAWIDTH = 16,
   parameter int NREGS     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATAWIDTH-1:0] spi_data,
   input  logic                 spi_data_rdy,
   input  logic                 spi_sclk,
   output logic [NREGS*8-1:0]   led_regs,
   output logic                 frame_valid,
   output logic                 frame_err,
   output logic [7:0]           frame_count
);
   localparam int         ADDRW    = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [4:0] CNT_MAX  = 5'd31;
   localparam logic [4:0] CNT_FULL = 5'(DATAWIDTH);
   localparam logic [4:0] NREGS_W  = 5'(NREGS);

   typedef enum logic [1:0] {IDLE, RECV, CHECK, APPLY} state_t;
   state_t state_reg, state_next;

   logic       rdy_s1_reg, rdy_s2_reg, rdy_d_reg;
   logic       sclk_s1_reg, sclk_s2_reg, sclk_d_reg;
   logic [2:0] live_reg;
   logic       rdy_fall, rdy_rise, sclk_rise;

   logic             cnt_clr, cnt_inc, pend_set, pend_clr, capture, apply;
   logic [4:0]       cnt_reg;
   logic             pend_reg;
   logic [3:0]       op_reg;
   logic [ADDRW-1:0] addr_reg;
   logic [7:0]       val_reg;
   logic             err_reg;
   logic             cmd_err;
   logic [7:0]       regs_reg [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_s1_reg  <= 1'b1;
         rdy_s2_reg  <= 1'b1;
         rdy_d_reg   <= 1'b1;
         sclk_s1_reg <= 1'b0;
         sclk_s2_reg <= 1'b0;
         sclk_d_reg  <= 1'b0;
         live_reg    <= '0;
      end else begin
         rdy_s1_reg  <= spi_data_rdy;
         rdy_s2_reg  <= rdy_s1_reg;
         rdy_d_reg   <= rdy_s2_reg;
         sclk_s1_reg <= spi_sclk;
         sclk_s2_reg <= sclk_s1_reg;
         sclk_d_reg  <= sclk_s2_reg;
         live_reg    <= {live_reg[1:0], 1'b1};
      end
   end

   // A fall against the preset idle level is not a real edge: a frame already in
   // progress at reset release must be dropped, so wait until rdy_d holds a real sample.
   assign rdy_fall  = ~rdy_s2_reg & rdy_d_reg & live_reg[2];
   assign rdy_rise  = rdy_s2_reg & ~rdy_d_reg;
   assign sclk_rise = sclk_s2_reg & ~sclk_d_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      capture    = 1'b0;
      apply      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rdy_fall) begin
               state_next = RECV;
               cnt_clr    = 1'b1;
            end
         end
         RECV: begin
            cnt_inc = sclk_rise;
            if (rdy_rise) state_next = CHECK;
         end
         CHECK: begin
            capture    = 1'b1;
            pend_set   = rdy_fall;
            state_next = APPLY;
         end
         APPLY: begin
            apply    = 1'b1;
            pend_clr = 1'b1;
            if (pend_reg || rdy_fall) begin
               state_next = RECV;
               cnt_clr    = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cmd_err = (cnt_reg != CNT_FULL) ||
                    (spi_data[15:12] > 4'h2) ||
                    ((spi_data[15:12] == 4'h1) && ({1'b0, spi_data[11:8]} >= NREGS_W));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg  <= '0;
         pend_reg <= 1'b0;
         op_reg   <= '0;
         addr_reg <= '0;
         val_reg  <= '0;
         err_reg  <= 1'b0;
      end else begin
         if (cnt_clr)                           cnt_reg <= '0;
         else if (cnt_inc && cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 5'd1;

         if (pend_clr)      pend_reg <= 1'b0;
         else if (pend_set) pend_reg <= 1'b1;

         if (capture) begin
            op_reg   <= spi_data[15:12];
            addr_reg <= spi_data[8 +: ADDRW];
            val_reg  <= spi_data[7:0];
            err_reg  <= cmd_err;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
      end else begin
         frame_valid <= apply & ~err_reg;
         frame_err   <= apply & err_reg;
         if (apply && !err_reg) begin
            frame_count <= frame_count + 8'd1;
            case (op_reg)
               4'h1:    regs_reg[addr_reg] <= val_reg;
               4'h2:    for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
               default: ;
            endcase
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
         assign led_regs[gi*8 +: 8] = regs_reg[gi];
      end
   endgenerate
endmodule
